// File: rtl/sha2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sha2_pkg                                                   |
// | Purpose  : Shared SHA-2 constants, FSM encodings and helper function. |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package sha2_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int ROUNDS      = 64;
    localparam int BLOCK_WORDS = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] READY  = 2'd2;

    // Ceiling log2, with a floor of zero bits for value <= 1.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_small_sigma.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sha256_small_sigma                                         |
// | Purpose  : Combinational SHA-256 small sigma0 / sigma1 functions.     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module sha256_small_sigma (
    input  logic [31:0] i_word,
    output logic [31:0] o_sigma0,
    output logic [31:0] o_sigma1
);

    assign o_sigma0 = {i_word[6:0],  i_word[31:7]}  ^
                      {i_word[17:0], i_word[31:18]} ^
                      (i_word >> 3);

    assign o_sigma1 = {i_word[16:0], i_word[31:17]} ^
                      {i_word[18:0], i_word[31:19]} ^
                      (i_word >> 10);

endmodule
`default_nettype wire

// File: rtl/message_schedule_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : message_schedule_gen                                       |
// | Purpose  : Expands one 512-bit block into W[0..63], then serves reads.|
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module message_schedule_gen #(
    parameter int WORD_SIZE = 32,
    parameter int ROUNDS    = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [16*WORD_SIZE-1:0] block_in,
    input  logic                   block_valid,
    output logic                   block_ready,
    output logic                   schedule_valid,
    input  logic [5:0]             message_schedule_index,
    output logic [WORD_SIZE-1:0]   message_schedule_value,
    input  logic                   schedule_release
);

    import sha2_pkg::*;

    localparam int                c_idx_w = clogb2(ROUNDS);
    localparam logic [c_idx_w-1:0] c_first = c_idx_w'(BLOCK_WORDS);
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(ROUNDS - 1);

    logic [1:0]           r_state;
    logic [c_idx_w-1:0]   r_t;
    logic                 r_block_ready;
    logic                 r_schedule_valid;
    logic [WORD_SIZE-1:0] r_store [ROUNDS];

    logic                 w_accept;
    logic [WORD_SIZE-1:0] w_tm2;
    logic [WORD_SIZE-1:0] w_tm7;
    logic [WORD_SIZE-1:0] w_tm15;
    logic [WORD_SIZE-1:0] w_tm16;
    logic [WORD_SIZE-1:0] w_s0;
    logic [WORD_SIZE-1:0] w_s1;
    logic [WORD_SIZE-1:0] w_unused_s1_of_tm15;
    logic [WORD_SIZE-1:0] w_unused_s0_of_tm2;
    logic [WORD_SIZE-1:0] w_new;

    assign w_accept = (r_state == IDLE) && block_valid;

    // t never drops below 16 in EXPAND, so the backward offsets never wrap.
    assign w_tm2  = r_store[r_t - c_idx_w'(2)];
    assign w_tm7  = r_store[r_t - c_idx_w'(7)];
    assign w_tm15 = r_store[r_t - c_idx_w'(15)];
    assign w_tm16 = r_store[r_t - c_idx_w'(16)];

    sha256_small_sigma u_sigma_tm15 (
        .i_word   (w_tm15),
        .o_sigma0 (w_s0),
        .o_sigma1 (w_unused_s1_of_tm15)
    );

    sha256_small_sigma u_sigma_tm2 (
        .i_word   (w_tm2),
        .o_sigma0 (w_unused_s0_of_tm2),
        .o_sigma1 (w_s1)
    );

    assign w_new = w_s1 + w_tm7 + w_s0 + w_tm16;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= IDLE;
            r_t              <= c_first;
            r_block_ready    <= 1'b1;
            r_schedule_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state       <= EXPAND;
                        r_t           <= c_first;
                        r_block_ready <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (r_t == c_last) begin
                        r_state          <= READY;
                        r_t              <= c_first;
                        r_schedule_valid <= 1'b1;
                    end else begin
                        r_t <= r_t + c_idx_w'(1);
                    end
                end
                READY: begin
                    if (schedule_release) begin
                        r_state          <= IDLE;
                        r_block_ready    <= 1'b1;
                        r_schedule_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= IDLE;
                    r_t              <= c_first;
                    r_block_ready    <= 1'b1;
                    r_schedule_valid <= 1'b0;
                end
            endcase
        end
    end

    // The store is deliberately not cleared by reset; only writes are gated.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_accept) begin
                for (int i = 0; i < BLOCK_WORDS; i++) begin
                    r_store[i] <= block_in[(BLOCK_WORDS-1-i)*WORD_SIZE +: WORD_SIZE];
                end
            end else if (r_state == EXPAND) begin
                r_store[r_t] <= w_new;
            end
        end
    end

    assign block_ready            = r_block_ready;
    assign schedule_valid         = r_schedule_valid;
    assign message_schedule_value = r_store[message_schedule_index];

endmodule
`default_nettype wire
